// File: rtl/sd_cmd_frame_serializer_pkg.sv
// Shared definitions for the SD CMD-line frame serializer and its CRC7 helper.
// Provides frame widths, the CRC7 polynomial, the serializer state encoding
// and a single-bit CRC7 update function reused by the TX and RX CRC blocks.
package sd_cmd_frame_serializer_pkg;

  localparam int FRAME_R1     = 48;
  localparam int FRAME_R2     = 136;
  localparam int FRAME_MIN    = 16;
  // CRC7 plus end bit occupy the last 8 bits of a frame when CRC is inserted.
  localparam int TRAILER_BITS = 8;
  // R2 frames keep start, dir and the reserved 111111 field out of the CRC.
  localparam int R2_HDR_BITS  = 8;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_DATA = 3'd1,
    ST_SEND_CRC  = 3'd2,
    ST_SEND_END  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // One serial step of CRC7 (x^7 + x^3 + 1), message bit presented MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_frame_serializer_crc7.sv
// Serial CRC7 generator shared by the CMD TX serializer and the RX checker.
// Ports: sd_clock/reset (async, active-low); clear zeroes the register and,
// when enable is also high, the same edge absorbs din into the cleared value;
// enable absorbs din; crc is the current 7-bit remainder.
module sd_crc7
  import sd_cmd_frame_serializer_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_r;
  logic [6:0] base_s;
  logic [6:0] crc_nxt_s;

  // Next remainder: optional clear first, then optional one-bit update.
  always_comb begin
    base_s    = clear ? 7'h00 : crc_r;
    crc_nxt_s = base_s;
    if (enable) begin
      crc_nxt_s = crc7_step(base_s, din);
    end else begin
      crc_nxt_s = base_s;
    end
  end

  // CRC remainder register.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      crc_r <= 7'h00;
    end else begin
      crc_r <= crc_nxt_s;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/sd_cmd_frame_serializer.sv
// SD CMD-line frame serializer: shifts a 48-bit or 136-bit frame out MSB first
// on cmd_pin, optionally appending an internally generated CRC7 and end bit.
// Ports: sd_clock/reset (async, active-low); enable (low aborts); load_send
// start strobe; frame_len total bits; crc_insert; payload left-aligned frame;
// ack_in releases complete. Outputs cmd_pin (idles 1), cmd_oe, busy, complete,
// len_err are all registered.
module sd_cmd_frame_serializer
  import sd_cmd_frame_serializer_pkg::*;
#(
  parameter int MAX_FRAME = 136,
  parameter int LEN_W     = 8,
  parameter int CRC_EN    = 1
)
(
  input  logic                 sd_clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load_send,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 crc_insert,
  input  logic [MAX_FRAME-1:0] payload,
  input  logic                 ack_in,
  output logic                 cmd_pin,
  output logic                 cmd_oe,
  output logic                 busy,
  output logic                 complete,
  output logic                 len_err
);

  localparam logic [LEN_W-1:0] CNT_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_CRC   = LEN_W'(6);
  localparam logic [LEN_W-1:0] TRIM_CRC  = LEN_W'(TRAILER_BITS + 1);
  localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(FRAME_MIN);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] LEN_R2    = LEN_W'(FRAME_R2);
  localparam logic [3:0]       SKIP_INIT = 4'(R2_HDR_BITS - 1);

  state_t                 state_r, next_state_s;
  logic [MAX_FRAME-1:0]   shift_r, shift_nxt_s;
  logic [LEN_W-1:0]       cnt_r, cnt_nxt_s;
  logic [3:0]             skip_r, skip_nxt_s;
  logic                   crc_on_r, crc_on_nxt_s;
  logic                   pin_r, oe_r, busy_r, complete_r, len_err_r;
  logic                   pin_bit_s, drive_nxt_s;
  logic                   len_ok_s, start_ok_s, crc_on_s, r2_s;
  logic                   crc_clear_s, crc_en_s, crc_din_s;
  logic [6:0]             crc_s;

  assign len_ok_s    = (frame_len >= LEN_MIN) && (frame_len <= LEN_MAX);
  assign start_ok_s  = enable && load_send && len_ok_s;
  assign crc_on_s    = (CRC_EN != 0) ? crc_insert : 1'b0;
  assign r2_s        = (frame_len == LEN_R2);
  assign drive_nxt_s = (next_state_s == ST_SEND_DATA) || (next_state_s == ST_SEND_CRC) ||
                       (next_state_s == ST_SEND_END);

  sd_crc7 u_crc7 (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (crc_clear_s),
    .enable   (crc_en_s),
    .din      (crc_din_s),
    .crc      (crc_s)
  );

  // State register.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; enable low returns to IDLE from anywhere.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) next_state_s = ST_SEND_DATA;
        else            next_state_s = ST_IDLE;
      end
      ST_SEND_DATA: begin
        if (!enable)              next_state_s = ST_IDLE;
        else if (cnt_r == CNT_ZERO) next_state_s = crc_on_r ? ST_SEND_CRC : ST_DONE;
        else                      next_state_s = ST_SEND_DATA;
      end
      ST_SEND_CRC: begin
        if (!enable)              next_state_s = ST_IDLE;
        else if (cnt_r == CNT_ZERO) next_state_s = ST_SEND_END;
        else                      next_state_s = ST_SEND_CRC;
      end
      ST_SEND_END: begin
        if (!enable) next_state_s = ST_IDLE;
        else         next_state_s = ST_DONE;
      end
      ST_DONE: begin
        if (!enable || ack_in) next_state_s = ST_IDLE;
        else                   next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values. cmd_pin is registered, so each edge loads the
  // bit for the coming cycle and feeds the CRC with that same bit; the counter
  // holds how many bits of the current phase remain after the one on the line.
  always_comb begin
    shift_nxt_s  = shift_r;
    cnt_nxt_s    = cnt_r;
    skip_nxt_s   = skip_r;
    crc_on_nxt_s = crc_on_r;
    pin_bit_s    = 1'b1;
    crc_clear_s  = 1'b0;
    crc_en_s     = 1'b0;
    crc_din_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          pin_bit_s    = payload[MAX_FRAME-1];
          shift_nxt_s  = payload << 1;
          cnt_nxt_s    = crc_on_s ? (frame_len - TRIM_CRC) : (frame_len - CNT_ONE);
          crc_on_nxt_s = crc_on_s;
          skip_nxt_s   = r2_s ? SKIP_INIT : 4'd0;
          crc_clear_s  = 1'b1;
          crc_en_s     = !r2_s;
          crc_din_s    = payload[MAX_FRAME-1];
        end else begin
          pin_bit_s = 1'b1;
        end
      end
      ST_SEND_DATA: begin
        if (cnt_r != CNT_ZERO) begin
          pin_bit_s   = shift_r[MAX_FRAME-1];
          shift_nxt_s = shift_r << 1;
          cnt_nxt_s   = cnt_r - CNT_ONE;
          crc_en_s    = (skip_r == 4'd0);
          crc_din_s   = shift_r[MAX_FRAME-1];
          if (skip_r != 4'd0) skip_nxt_s = skip_r - 4'd1;
          else                skip_nxt_s = skip_r;
        end else if (crc_on_r) begin
          // Last data bit already absorbed: park the remaining CRC bits in the
          // shift register so SEND_CRC reuses the same shift path.
          pin_bit_s   = crc_s[6];
          shift_nxt_s = {crc_s[5:0], 1'b1, {(MAX_FRAME-7){1'b0}}};
          cnt_nxt_s   = CNT_CRC;
        end else begin
          pin_bit_s = 1'b1;
        end
      end
      ST_SEND_CRC: begin
        if (cnt_r != CNT_ZERO) begin
          pin_bit_s   = shift_r[MAX_FRAME-1];
          shift_nxt_s = shift_r << 1;
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end else begin
          pin_bit_s = 1'b1;
        end
      end
      ST_SEND_END: pin_bit_s = 1'b1;
      ST_DONE:     pin_bit_s = 1'b1;
      default:     pin_bit_s = 1'b1;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      shift_r    <= {MAX_FRAME{1'b0}};
      cnt_r      <= CNT_ZERO;
      skip_r     <= 4'd0;
      crc_on_r   <= 1'b0;
      pin_r      <= 1'b1;
      oe_r       <= 1'b0;
      busy_r     <= 1'b0;
      complete_r <= 1'b0;
      len_err_r  <= 1'b0;
    end else begin
      shift_r    <= shift_nxt_s;
      cnt_r      <= cnt_nxt_s;
      skip_r     <= skip_nxt_s;
      crc_on_r   <= crc_on_nxt_s;
      pin_r      <= drive_nxt_s ? pin_bit_s : 1'b1;
      oe_r       <= drive_nxt_s;
      busy_r     <= (next_state_s != ST_IDLE);
      complete_r <= (next_state_s == ST_DONE);
      len_err_r  <= (state_r == ST_IDLE) && enable && load_send && !len_ok_s;
    end
  end

  assign cmd_pin  = pin_r;
  assign cmd_oe   = oe_r;
  assign busy     = busy_r;
  assign complete = complete_r;
  assign len_err  = len_err_r;

endmodule

// File: tb/tb_sd_cmd_frame_serializer.sv
// Self-checking bench for sd_cmd_frame_serializer: table of frames with
// hand-computed line images, plus abort, len_err and mid-frame-strobe sequences.
module tb_sd_cmd_frame_serializer;

  logic         sd_clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         load_send;
  logic [7:0]   frame_len;
  logic         crc_insert;
  logic [135:0] payload;
  logic         ack_in;
  logic         cmd_pin, cmd_oe, busy, complete, len_err;

  int checks   = 0;
  int failures = 0;

  sd_cmd_frame_serializer #(.MAX_FRAME(136), .LEN_W(8), .CRC_EN(1)) dut (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .enable     (enable),
    .load_send  (load_send),
    .frame_len  (frame_len),
    .crc_insert (crc_insert),
    .payload    (payload),
    .ack_in     (ack_in),
    .cmd_pin    (cmd_pin),
    .cmd_oe     (cmd_oe),
    .busy       (busy),
    .complete   (complete),
    .len_err    (len_err)
  );

  always #5 sd_clock = ~sd_clock;

  typedef struct {
    logic [135:0] pl;
    logic [7:0]   len;
    logic         crc;
    int           disturb;
    logic [135:0] exp_line;
    int           exp_bits;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // CRC7 as polynomial long division of msg * x^7 by x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_div(input logic [135:0] msg, input int nbits);
    logic [7:0] rem;
    rem = 8'h00;
    for (int i = nbits - 1; i >= 0; i--) begin
      rem = {rem[6:0], msg[i]};
      if (rem[7]) rem = rem ^ 8'h89;
    end
    for (int j = 0; j < 7; j++) begin
      rem = {rem[6:0], 1'b0};
      if (rem[7]) rem = rem ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  // Start a frame and record every bit driven while cmd_oe stays high.
  task automatic run_frame(input logic [135:0] pl, input logic [7:0] len, input logic crc,
                           input int disturb_at, output logic [135:0] line,
                           output int nbits, output logic oe_first);
    @(negedge sd_clock);
    payload = pl; frame_len = len; crc_insert = crc; load_send = 1'b1;
    @(negedge sd_clock);
    load_send = 1'b0;
    oe_first  = cmd_oe;
    line      = 136'h0;
    nbits     = 0;
    while (cmd_oe === 1'b1 && nbits < 200) begin
      line = {line[134:0], cmd_pin};
      nbits++;
      if (nbits == disturb_at) begin
        payload = ~pl; frame_len = 8'd16; crc_insert = ~crc; load_send = 1'b1;
      end else begin
        load_send = 1'b0;
      end
      @(negedge sd_clock);
    end
    load_send = 1'b0;
  endtask

  // Check DONE holds complete, then acknowledge and check release.
  task automatic ack_frame(input string tag);
    chk({tag, "_complete"}, {135'h0, complete}, 136'h1);
    chk({tag, "_busy_done"}, {135'h0, busy}, 136'h1);
    repeat (2) @(negedge sd_clock);
    chk({tag, "_complete_held"}, {135'h0, complete}, 136'h1);
    ack_in = 1'b1;
    @(negedge sd_clock);
    ack_in = 1'b0;
    chk({tag, "_complete_clr"}, {135'h0, complete}, 136'h0);
    chk({tag, "_busy_clr"}, {135'h0, busy}, 136'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [135:0] line;
    logic [127:0] r2_data;
    logic [7:0]   bad_len[4];
    int           nbits;
    logic         oe_first;

    reset = 1'b0; enable = 1'b0; load_send = 1'b0; frame_len = 8'd0;
    crc_insert = 1'b0; payload = 136'h0; ack_in = 1'b0;

    r2_data = {8'h3F, 120'h02_4d4f_4230_3132_3334_0a56_789a_bcde};
    vecs[0] = '{{48'h4000000000FF, 88'h0}, 8'd48, 1'b1, -1, 136'h400000000095, 48};
    vecs[1] = '{{48'h48000001AA00, 88'h0}, 8'd48, 1'b1, -1, 136'h48000001AA87, 48};
    vecs[2] = '{{48'h510000000055, 88'h0}, 8'd48, 1'b0, -1, 136'h510000000055, 48};
    vecs[3] = '{{r2_data, 8'hFF}, 8'd136, 1'b1, -1,
                {r2_data, crc7_div({16'h0, r2_data[119:0]}, 120), 1'b1}, 136};
    vecs[4] = '{{48'h48000001AA00, 88'h0}, 8'd48, 1'b1, 5, 136'h48000001AA87, 48};
    vecs[5] = '{{16'h40FF, 120'h0}, 8'd16, 1'b1, -1,
                {120'h0, 8'h40, crc7_div(136'h40, 8), 1'b1}, 16};
    bad_len = '{8'd8, 8'd200, 8'd15, 8'd137};

    repeat (3) @(negedge sd_clock);
    chk("rst_pin", {135'h0, cmd_pin}, 136'h1);
    chk("rst_oe", {135'h0, cmd_oe}, 136'h0);
    chk("rst_busy", {135'h0, busy}, 136'h0);
    chk("rst_complete", {135'h0, complete}, 136'h0);
    chk("rst_len_err", {135'h0, len_err}, 136'h0);

    reset = 1'b1; enable = 1'b1;
    @(negedge sd_clock);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].pl, vecs[v].len, vecs[v].crc, vecs[v].disturb, line, nbits, oe_first);
      chk($sformatf("vec%0d_first_oe", v), {135'h0, oe_first}, 136'h1);
      chk($sformatf("vec%0d_nbits", v), 136'(nbits), 136'(vecs[v].exp_bits));
      chk($sformatf("vec%0d_line", v), line, vecs[v].exp_line);
      ack_frame($sformatf("vec%0d", v));
    end

    // Abort at bit 20 of a 48-bit frame, then restart cleanly.
    @(negedge sd_clock);
    payload = vecs[0].pl; frame_len = 8'd48; crc_insert = 1'b1; load_send = 1'b1;
    @(negedge sd_clock);
    load_send = 1'b0;
    repeat (19) @(negedge sd_clock);
    chk("abort_oe_before", {135'h0, cmd_oe}, 136'h1);
    enable = 1'b0;
    @(negedge sd_clock);
    chk("abort_pin", {135'h0, cmd_pin}, 136'h1);
    chk("abort_oe", {135'h0, cmd_oe}, 136'h0);
    chk("abort_busy", {135'h0, busy}, 136'h0);
    repeat (3) @(negedge sd_clock);
    chk("abort_no_complete", {135'h0, complete}, 136'h0);
    enable = 1'b1;
    run_frame(vecs[0].pl, 8'd48, 1'b1, -1, line, nbits, oe_first);
    chk("restart_nbits", 136'(nbits), 136'd48);
    chk("restart_line", line, 136'h400000000095);
    ack_frame("restart");

    // Illegal lengths are rejected with a one-cycle len_err pulse.
    for (int k = 0; k < 4; k++) begin
      @(negedge sd_clock);
      frame_len = bad_len[k]; crc_insert = 1'b1; load_send = 1'b1;
      @(negedge sd_clock);
      load_send = 1'b0;
      chk($sformatf("lenerr%0d_pulse", bad_len[k]), {135'h0, len_err}, 136'h1);
      chk($sformatf("lenerr%0d_busy", bad_len[k]), {135'h0, busy}, 136'h0);
      chk($sformatf("lenerr%0d_oe", bad_len[k]), {135'h0, cmd_oe}, 136'h0);
      @(negedge sd_clock);
      chk($sformatf("lenerr%0d_drop", bad_len[k]), {135'h0, len_err}, 136'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
